// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage load/store engine.
package mem_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // RV32I funct3 encodings for loads and stores
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // resultsrc value that selects memory data as the writeback source
  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores, sign/zero extension for loads, and
// misalignment / illegal-encoding detection. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic        fault,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Store lane replication, byte enables and fault classification
  always_comb begin
    wstrb = 4'b0000;
    wdata = '0;
    fault = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wstrb = 4'b0001 << byte_offset;
          wdata = {4{store_data[7:0]}};
        end
        F3_SH: begin
          wstrb = 4'b0011 << byte_offset;
          wdata = {2{store_data[15:0]}};
          fault = byte_offset[0];
        end
        F3_SW: begin
          wstrb = 4'b1111;
          wdata = store_data;
          fault = |byte_offset;
        end
        default: fault = 1'b1;
      endcase
    end else if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: fault = 1'b0;
        F3_LH, F3_LHU: fault = byte_offset[0];
        F3_LW:         fault = |byte_offset;
        default:       fault = 1'b1;
      endcase
    end
  end

  // Select the addressed byte/halfword and extend it to a full word
  always_comb begin
    case (load_offset)
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = load_offset[1] ? load_word[31:16] : load_word[15:0];
    case (load_funct3)
      F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      F3_LBU:  load_data = {24'd0, load_byte};
      F3_LH:   load_data = {{16{load_half[15]}}, load_half};
      F3_LHU:  load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: turns the M-stage access into one
// word-aligned request, stalls the pipeline until it completes, and
// returns extended load data for writeback.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] aluresultm,
  input  logic [DATA_WIDTH-1:0]    writedatam,
  input  logic                     memwritem,
  input  logic [1:0]               resultsrcm,
  input  logic [2:0]               funct3m,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_wstrb,
  input  logic                     mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [DATA_WIDTH-1:0]    readdatam,
  output logic                     stallm,
  output logic                     memfaultm
);

  mem_state_t state;

  logic        is_store;
  logic        is_load;
  logic        lane_fault;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;

  assign is_store = memwritem;
  assign is_load  = (resultsrcm == RESULTSRC_MEM) && !memwritem;

  mem_lane_align u_lane (
    .funct3      (funct3m),
    .byte_offset (aluresultm[1:0]),
    .is_load     (is_load),
    .is_store    (is_store),
    .store_data  (writedatam),
    .wstrb       (lane_wstrb),
    .wdata       (lane_wdata),
    .fault       (lane_fault),
    .load_funct3 (ld_funct3),
    .load_offset (ld_offset),
    .load_word   (mem_rdata),
    .load_data   (load_data)
  );

  // Stall and fault flags: stall starts in the same cycle the access is seen
  always_comb begin
    stallm    = 1'b0;
    memfaultm = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          stallm    = (is_store || is_load) && !lane_fault;
          memfaultm = lane_fault;
        end
        REQ, WAIT: stallm = 1'b1;
        default:   stallm = 1'b0;
      endcase
    end
  end

  // Access sequencer with registered request payload and load result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= 4'b0000;
      readdatam     <= '0;
      ld_funct3     <= 3'b000;
      ld_offset     <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if ((is_store || is_load) && !lane_fault) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_we        <= is_store;
            mem_addr      <= {aluresultm[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata     <= lane_wdata;
            mem_wstrb     <= lane_wstrb;
            ld_funct3     <= funct3m;
            ld_offset     <= aluresultm[1:0];
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            readdatam <= load_data;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
